// File: rtl/uart_cmd_rx.sv
// UART command receiver: 2-flop synchronizer, 8N1 deframer and HEAD/ADDR/DATA/CHK frame parser.
// Define PARITY_EN to build the 8E1 variant with even-parity checking and par_err reporting.
module uart_cmd_rx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter logic [7:0]  HEAD_BYTE    = 8'hA5,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       rx_in,
    output logic       cmd_valid,
    output logic [7:0] cmd_addr,
    output logic [7:0] cmd_data,
    output logic       frame_err,
    output logic       chk_err,
    output logic       par_err,
    output logic       busy
);
    localparam int unsigned HALF_BIT  = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int unsigned TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned TO_W      = $clog2(TO_CYCLES + 1);

    typedef enum logic [2:0] {B_IDLE, B_START, B_DATA, B_PARITY, B_STOP} bit_state_t;
    typedef enum logic [1:0] {P_HUNT, P_ADDR, P_DATA, P_CHK} parse_state_t;

    logic             r_rx_meta;
    logic             r_rx_sync;
    bit_state_t       r_bstate;
    parse_state_t     r_pstate;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_addr_tmp;
    logic [7:0]       r_data_tmp;
    logic [TO_W-1:0]  r_idle_cnt;

    logic w_bit_end;
    logic w_stop_sample;
    logic w_byte_ok;
    logic w_start_seen;
    logic w_timeout;
    logic w_par_bad;

`ifdef PARITY_EN
    logic r_par_bad;
    assign w_par_bad = r_par_bad;
`else
    assign w_par_bad = 1'b0;
    assign par_err   = 1'b0;
`endif

    assign w_bit_end     = (r_bit_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign w_stop_sample = (r_bstate == B_STOP) && w_bit_end;
    assign w_byte_ok     = w_stop_sample && r_rx_sync && !w_par_bad;
    assign w_start_seen  = (r_bstate == B_IDLE) && !r_rx_sync;
    assign w_timeout     = (r_pstate != P_HUNT) && (r_bstate == B_IDLE) && r_rx_sync
                           && (r_idle_cnt == TO_W'(TO_CYCLES - 1));

    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_bstate   <= B_IDLE;
            r_pstate   <= P_HUNT;
            r_bit_cnt  <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_addr_tmp <= '0;
            r_data_tmp <= '0;
            r_idle_cnt <= '0;
            cmd_valid  <= 1'b0;
            cmd_addr   <= '0;
            cmd_data   <= '0;
            frame_err  <= 1'b0;
            chk_err    <= 1'b0;
            busy       <= 1'b0;
`ifdef PARITY_EN
            r_par_bad  <= 1'b0;
            par_err    <= 1'b0;
`endif
        end else begin
            r_rx_meta <= rx_in;
            r_rx_sync <= r_rx_meta;
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
            chk_err   <= 1'b0;
`ifdef PARITY_EN
            par_err   <= 1'b0;
`endif
            busy      <= (r_pstate != P_HUNT) || (r_bstate != B_IDLE);
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);

            // Bit engine: every sample is taken at the bit centre.
            case (r_bstate)
                B_IDLE: begin
                    r_bit_cnt <= '0;
                    if (!r_rx_sync) r_bstate <= B_START;
                end
                B_START: begin
                    if (r_bit_cnt == CNT_W'(HALF_BIT - 1)) begin
                        r_bit_cnt <= '0;
                        r_bit_idx <= '0;
                        r_bstate  <= r_rx_sync ? B_IDLE : B_DATA;
                    end
                end
                B_DATA: begin
                    if (w_bit_end) begin
                        r_bit_cnt <= '0;
                        r_shift   <= {r_rx_sync, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
`ifdef PARITY_EN
                            r_bstate <= B_PARITY;
`else
                            r_bstate <= B_STOP;
`endif
                        end
                    end
                end
`ifdef PARITY_EN
                B_PARITY: begin
                    if (w_bit_end) begin
                        r_bit_cnt <= '0;
                        r_par_bad <= (r_rx_sync != (^r_shift));
                        r_bstate  <= B_STOP;
                    end
                end
`endif
                B_STOP: begin
                    if (w_bit_end) begin
                        r_bstate <= B_IDLE;
                        if (!r_rx_sync) frame_err <= 1'b1;
`ifdef PARITY_EN
                        else if (r_par_bad) par_err <= 1'b1;
`endif
                    end
                end
                default: r_bstate <= B_IDLE;
            endcase

            // Inactivity timer only runs while a frame is partially received.
            if (w_timeout || w_start_seen || (r_pstate == P_HUNT)) r_idle_cnt <= '0;
            else if (r_bstate == B_IDLE) r_idle_cnt <= r_idle_cnt + TO_W'(1);

            if (w_stop_sample && !w_byte_ok) begin
                r_pstate <= P_HUNT;
            end else if (w_byte_ok) begin
                case (r_pstate)
                    P_HUNT: if (r_shift == HEAD_BYTE) r_pstate <= P_ADDR;
                    P_ADDR: begin
                        r_addr_tmp <= r_shift;
                        r_pstate   <= P_DATA;
                    end
                    P_DATA: begin
                        r_data_tmp <= r_shift;
                        r_pstate   <= P_CHK;
                    end
                    default: begin
                        if (r_shift == (r_addr_tmp ^ r_data_tmp)) begin
                            cmd_valid <= 1'b1;
                            cmd_addr  <= r_addr_tmp;
                            cmd_data  <= r_data_tmp;
                        end else begin
                            chk_err <= 1'b1;
                        end
                        r_pstate <= P_HUNT;
                    end
                endcase
            end else if (w_timeout) begin
                r_pstate <= P_HUNT;
            end
        end
    end
endmodule
